l2_port_arbiter: RTL and testbench

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

---
 rtl/l2_port_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
//   Two-requester arbiter in front of the l2_cache AXI4 inport. Read and
//   write paths are separate FSMs, each carrying one single-beat
//   transaction at a time and each with its own round-robin pointer.
//
// Handshake rule (all channels): a beat transfers on a rising clk_i edge
// where valid and ready are both high. A master holds valid and payload
// stable until that edge; the arbiter never creates a valid or ready for a
// requester that does not own the path in the matching state.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   m0_* / m1_*            requester AXI4 slave ports (AR, R, AW, W, B)
//   s_*                    downstream AXI4 master port to l2_cache
//   rd_gnt_o / wr_gnt_o    one-hot owner of each path, 2'b00 when idle
//   dbg_rd_state_o/dbg_wr_state_o  FSM state, for observation only
module l2_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int CORE_DATA_W = 256,
  parameter int ID_W        = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // requester 0
  input  logic                     m0_arvalid_i,
  input  logic [ADDR_W-1:0]        m0_araddr_i,
  input  logic [ID_W-1:0]          m0_arid_i,
  output logic                     m0_arready_o,
  output logic                     m0_rvalid_o,
  output logic [CORE_DATA_W-1:0]   m0_rdata_o,
  output logic [1:0]               m0_rresp_o,
  output logic [ID_W-1:0]          m0_rid_o,
  output logic                     m0_rlast_o,
  input  logic                     m0_rready_i,
  input  logic                     m0_awvalid_i,
  input  logic [ADDR_W-1:0]        m0_awaddr_i,
  input  logic [ID_W-1:0]          m0_awid_i,
  output logic                     m0_awready_o,
  input  logic                     m0_wvalid_i,
  input  logic [CORE_DATA_W-1:0]   m0_wdata_i,
  input  logic [CORE_DATA_W/8-1:0] m0_wstrb_i,
  input  logic                     m0_wlast_i,
  output logic                     m0_wready_o,
  output logic                     m0_bvalid_o,
  output logic [1:0]               m0_bresp_o,
  output logic [ID_W-1:0]          m0_bid_o,
  input  logic                     m0_bready_i,
  // requester 1
  input  logic                     m1_arvalid_i,
  input  logic [ADDR_W-1:0]        m1_araddr_i,
  input  logic [ID_W-1:0]          m1_arid_i,
  output logic                     m1_arready_o,
  output logic                     m1_rvalid_o,
  output logic [CORE_DATA_W-1:0]   m1_rdata_o,
  output logic [1:0]               m1_rresp_o,
  output logic [ID_W-1:0]          m1_rid_o,
  output logic                     m1_rlast_o,
  input  logic                     m1_rready_i,
  input  logic                     m1_awvalid_i,
  input  logic [ADDR_W-1:0]        m1_awaddr_i,
  input  logic [ID_W-1:0]          m1_awid_i,
  output logic                     m1_awready_o,
  input  logic                     m1_wvalid_i,
  input  logic [CORE_DATA_W-1:0]   m1_wdata_i,
  input  logic [CORE_DATA_W/8-1:0] m1_wstrb_i,
  input  logic                     m1_wlast_i,
  output logic                     m1_wready_o,
  output logic                     m1_bvalid_o,
  output logic [1:0]               m1_bresp_o,
  output logic [ID_W-1:0]          m1_bid_o,
  input  logic                     m1_bready_i,
  // downstream
  output logic                     s_arvalid_o,
  input  logic                     s_arready_i,
  output logic [ADDR_W-1:0]        s_araddr_o,
  output logic [ID_W-1:0]          s_arid_o,
  output logic [7:0]               s_arlen_o,
  output logic [1:0]               s_arburst_o,
  output logic [2:0]               s_arsize_o,
  input  logic                     s_rvalid_i,
  output logic                     s_rready_o,
  input  logic [CORE_DATA_W-1:0]   s_rdata_i,
  input  logic [1:0]               s_rresp_i,
  input  logic [ID_W-1:0]          s_rid_i,
  input  logic                     s_rlast_i,
  output logic                     s_awvalid_o,
  input  logic                     s_awready_i,
  output logic [ADDR_W-1:0]        s_awaddr_o,
  output logic [ID_W-1:0]          s_awid_o,
  output logic [7:0]               s_awlen_o,
  output logic [1:0]               s_awburst_o,
  output logic [2:0]               s_awsize_o,
  output logic                     s_wvalid_o,
  input  logic                     s_wready_i,
  output logic [CORE_DATA_W-1:0]   s_wdata_o,
  output logic [CORE_DATA_W/8-1:0] s_wstrb_o,
  output logic                     s_wlast_o,
  input  logic                     s_bvalid_i,
  output logic                     s_bready_o,
  input  logic [1:0]               s_bresp_i,
  input  logic [ID_W-1:0]          s_bid_i,
  // status
  output logic [1:0]               rd_gnt_o,
  output logic [1:0]               wr_gnt_o,
  output logic [1:0]               dbg_rd_state_o,
  output logic [1:0]               dbg_wr_state_o
);

  localparam logic [2:0] BEAT_SIZE = 3'($clog2(CORE_DATA_W/8));

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_DATA = 2'd2, WR_RESP = 2'd3} wr_state_t;

  // r_*_sel: owner of the path (0 = m0, 1 = m1), valid outside IDLE.
  // r_*_ptr: side that wins when both request in the same cycle.
  rd_state_t r_rd_state, w_rd_state_nxt;
  wr_state_t r_wr_state, w_wr_state_nxt;
  logic      r_rd_sel, w_rd_sel_nxt, r_rd_ptr, w_rd_ptr_nxt;
  logic      r_wr_sel, w_wr_sel_nxt, r_wr_ptr, w_wr_ptr_nxt;
  logic      w_s_arvalid, w_s_rready, w_s_awvalid, w_s_wvalid, w_s_bready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
      r_rd_sel   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_state <= WR_IDLE;
      r_wr_sel   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_sel   <= w_rd_sel_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_state <= w_wr_state_nxt;
      r_wr_sel   <= w_wr_sel_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
    end
  end

  // Read path
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_sel_nxt   = r_rd_sel;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_s_arvalid    = 1'b0;
    w_s_rready     = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (m0_arvalid_i || m1_arvalid_i) begin
          // a lone requester wins; a tie goes to the pointer side
          w_rd_sel_nxt   = (m0_arvalid_i && m1_arvalid_i) ? r_rd_ptr : m1_arvalid_i;
          w_rd_ptr_nxt   = ~w_rd_sel_nxt;
          w_rd_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        w_s_arvalid = r_rd_sel ? m1_arvalid_i : m0_arvalid_i;
        if (w_s_arvalid && s_arready_i) w_rd_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        w_s_rready = r_rd_sel ? m1_rready_i : m0_rready_i;
        if (s_rvalid_i && w_s_rready && s_rlast_i) w_rd_state_nxt = RD_IDLE;
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Write path
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_sel_nxt   = r_wr_sel;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_s_awvalid    = 1'b0;
    w_s_wvalid     = 1'b0;
    w_s_bready     = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (m0_awvalid_i || m1_awvalid_i) begin
          w_wr_sel_nxt   = (m0_awvalid_i && m1_awvalid_i) ? r_wr_ptr : m1_awvalid_i;
          w_wr_ptr_nxt   = ~w_wr_sel_nxt;
          w_wr_state_nxt = WR_ADDR;
        end
      end
      WR_ADDR: begin
        w_s_awvalid = r_wr_sel ? m1_awvalid_i : m0_awvalid_i;
        if (w_s_awvalid && s_awready_i) w_wr_state_nxt = WR_DATA;
      end
      WR_DATA: begin
        w_s_wvalid = r_wr_sel ? m1_wvalid_i : m0_wvalid_i;
        if (w_s_wvalid && s_wready_i && s_wlast_o) w_wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        w_s_bready = r_wr_sel ? m1_bready_i : m0_bready_i;
        if (s_bvalid_i && w_s_bready) w_wr_state_nxt = WR_IDLE;
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Downstream read
  assign s_arvalid_o = w_s_arvalid;
  assign s_araddr_o  = r_rd_sel ? m1_araddr_i : m0_araddr_i;
  assign s_arid_o    = r_rd_sel ? m1_arid_i : m0_arid_i;
  assign s_arlen_o   = 8'd0;
  assign s_arburst_o = 2'b01;
  assign s_arsize_o  = BEAT_SIZE;
  assign s_rready_o  = w_s_rready;

  // Downstream write
  assign s_awvalid_o = w_s_awvalid;
  assign s_awaddr_o  = r_wr_sel ? m1_awaddr_i : m0_awaddr_i;
  assign s_awid_o    = r_wr_sel ? m1_awid_i : m0_awid_i;
  assign s_awlen_o   = 8'd0;
  assign s_awburst_o = 2'b01;
  assign s_awsize_o  = BEAT_SIZE;
  assign s_wvalid_o  = w_s_wvalid;
  assign s_wdata_o   = r_wr_sel ? m1_wdata_i : m0_wdata_i;
  assign s_wstrb_o   = r_wr_sel ? m1_wstrb_i : m0_wstrb_i;
  assign s_wlast_o   = r_wr_sel ? m1_wlast_i : m0_wlast_i;
  assign s_bready_o  = w_s_bready;

  // Requester side: handshake signals are steered by the grant register;
  // payloads are broadcast since only the owner ever sees a valid.
  assign m0_arready_o = (r_rd_state == RD_ADDR) && !r_rd_sel && s_arready_i;
  assign m1_arready_o = (r_rd_state == RD_ADDR) &&  r_rd_sel && s_arready_i;
  assign m0_rvalid_o  = (r_rd_state == RD_DATA) && !r_rd_sel && s_rvalid_i;
  assign m1_rvalid_o  = (r_rd_state == RD_DATA) &&  r_rd_sel && s_rvalid_i;
  assign m0_rdata_o   = s_rdata_i;
  assign m1_rdata_o   = s_rdata_i;
  assign m0_rresp_o   = s_rresp_i;
  assign m1_rresp_o   = s_rresp_i;
  assign m0_rid_o     = s_rid_i;
  assign m1_rid_o     = s_rid_i;
  assign m0_rlast_o   = s_rlast_i;
  assign m1_rlast_o   = s_rlast_i;

  assign m0_awready_o = (r_wr_state == WR_ADDR) && !r_wr_sel && s_awready_i;
  assign m1_awready_o = (r_wr_state == WR_ADDR) &&  r_wr_sel && s_awready_i;
  assign m0_wready_o  = (r_wr_state == WR_DATA) && !r_wr_sel && s_wready_i;
  assign m1_wready_o  = (r_wr_state == WR_DATA) &&  r_wr_sel && s_wready_i;
  assign m0_bvalid_o  = (r_wr_state == WR_RESP) && !r_wr_sel && s_bvalid_i;
  assign m1_bvalid_o  = (r_wr_state == WR_RESP) &&  r_wr_sel && s_bvalid_i;
  assign m0_bresp_o   = s_bresp_i;
  assign m1_bresp_o   = s_bresp_i;
  assign m0_bid_o     = s_bid_i;
  assign m1_bid_o     = s_bid_i;

  assign rd_gnt_o       = (r_rd_state == RD_IDLE) ? 2'b00 : {r_rd_sel, ~r_rd_sel};
  assign wr_gnt_o       = (r_wr_state == WR_IDLE) ? 2'b00 : {r_wr_sel, ~r_wr_sel};
  assign dbg_rd_state_o = r_rd_state;
  assign dbg_wr_state_o = r_wr_state;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed testbench for l2_port_arbiter. The bench plays both requesters
// and the downstream l2_cache port. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 time unit later, mid-cycle.
module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [AW-1:0] m0_araddr, m1_araddr;
  logic [IW-1:0] m0_arid, m1_arid;
  logic          m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    m0_rresp, m1_rresp;
  logic [IW-1:0] m0_rid, m1_rid;
  logic          m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [AW-1:0] m0_awaddr, m1_awaddr;
  logic [IW-1:0] m0_awid, m1_awid;
  logic          m0_wvalid, m1_wvalid, m0_wlast, m1_wlast, m0_wready, m1_wready;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb;
  logic          m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic [1:0]    m0_bresp, m1_bresp;
  logic [IW-1:0] m0_bid, m1_bid;

  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [IW-1:0] s_arid, s_rid, s_awid, s_bid;
  logic [7:0]    s_arlen, s_awlen;
  logic [1:0]    s_arburst, s_awburst, s_rresp, s_bresp;
  logic [2:0]    s_arsize, s_awsize;
  logic [DW-1:0] s_rdata, s_wdata;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [DW/8-1:0] s_wstrb;
  logic [1:0]    rd_gnt, wr_gnt, dbg_rd_state, dbg_wr_state;

  l2_port_arbiter #(.ADDR_W(AW), .CORE_DATA_W(DW), .ID_W(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_arvalid_i(m0_arvalid), .m0_araddr_i(m0_araddr), .m0_arid_i(m0_arid), .m0_arready_o(m0_arready),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_rresp_o(m0_rresp), .m0_rid_o(m0_rid),
    .m0_rlast_o(m0_rlast), .m0_rready_i(m0_rready),
    .m0_awvalid_i(m0_awvalid), .m0_awaddr_i(m0_awaddr), .m0_awid_i(m0_awid), .m0_awready_o(m0_awready),
    .m0_wvalid_i(m0_wvalid), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb), .m0_wlast_i(m0_wlast),
    .m0_wready_o(m0_wready), .m0_bvalid_o(m0_bvalid), .m0_bresp_o(m0_bresp), .m0_bid_o(m0_bid),
    .m0_bready_i(m0_bready),
    .m1_arvalid_i(m1_arvalid), .m1_araddr_i(m1_araddr), .m1_arid_i(m1_arid), .m1_arready_o(m1_arready),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_rresp_o(m1_rresp), .m1_rid_o(m1_rid),
    .m1_rlast_o(m1_rlast), .m1_rready_i(m1_rready),
    .m1_awvalid_i(m1_awvalid), .m1_awaddr_i(m1_awaddr), .m1_awid_i(m1_awid), .m1_awready_o(m1_awready),
    .m1_wvalid_i(m1_wvalid), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb), .m1_wlast_i(m1_wlast),
    .m1_wready_o(m1_wready), .m1_bvalid_o(m1_bvalid), .m1_bresp_o(m1_bresp), .m1_bid_o(m1_bid),
    .m1_bready_i(m1_bready),
    .s_arvalid_o(s_arvalid), .s_arready_i(s_arready), .s_araddr_o(s_araddr), .s_arid_o(s_arid),
    .s_arlen_o(s_arlen), .s_arburst_o(s_arburst), .s_arsize_o(s_arsize),
    .s_rvalid_i(s_rvalid), .s_rready_o(s_rready), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp),
    .s_rid_i(s_rid), .s_rlast_i(s_rlast),
    .s_awvalid_o(s_awvalid), .s_awready_i(s_awready), .s_awaddr_o(s_awaddr), .s_awid_o(s_awid),
    .s_awlen_o(s_awlen), .s_awburst_o(s_awburst), .s_awsize_o(s_awsize),
    .s_wvalid_o(s_wvalid), .s_wready_i(s_wready), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_wlast_o(s_wlast), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready), .s_bresp_i(s_bresp),
    .s_bid_i(s_bid),
    .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt), .dbg_rd_state_o(dbg_rd_state), .dbg_wr_state_o(dbg_wr_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] rdata_a, rdata_b, wdata_a;

  initial begin
    rdata_a = {8{32'hCAFE1100}};
    rdata_b = {8{32'h5EED0042}};
    wdata_a = {8{32'h0BADF00D}};
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_rready = 0;
    m0_awvalid = 0; m0_awaddr = '0; m0_awid = '0; m0_wvalid = 0; m0_wdata = '0; m0_wstrb = '0;
    m0_wlast = 0; m0_bready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
    m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rid = '0; s_rlast = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;

    // ---- reset state (requests present must not leak through) ----
    step();
    m0_arvalid = 1; m1_awvalid = 1; s_arready = 1; s_awready = 1;
    #1;
    chk("rst_rd_gnt", 256'(rd_gnt), 256'(2'b00));
    chk("rst_wr_gnt", 256'(wr_gnt), 256'(2'b00));
    chk("rst_s_arvalid", 256'(s_arvalid), 256'(1'b0));
    chk("rst_s_awvalid", 256'(s_awvalid), 256'(1'b0));
    chk("rst_m0_arready", 256'(m0_arready), 256'(1'b0));
    chk("rst_m1_awready", 256'(m1_awready), 256'(1'b0));
    chk("arlen", 256'(s_arlen), 256'(8'd0));
    chk("arburst", 256'(s_arburst), 256'(2'b01));
    chk("arsize", 256'(s_arsize), 256'(3'd5));
    chk("awsize", 256'(s_awsize), 256'(3'd5));
    m0_arvalid = 0; m1_awvalid = 0; s_arready = 0; s_awready = 0;
    step();
    rst = 0;

    // ---- simultaneous reads, twice: m0 first, then m1 ----
    step();
    m0_arvalid = 1; m0_araddr = 32'hA0; m0_arid = 4'd2;
    m1_arvalid = 1; m1_araddr = 32'hB0; m1_arid = 4'd1;
    #1;
    chk("rr_idle_s_arvalid", 256'(s_arvalid), 256'(1'b0));
    step();
    chk("rr1_rd_gnt", 256'(rd_gnt), 256'(2'b01));
    chk("rr1_s_araddr", 256'(s_araddr), 256'(32'hA0));
    s_arready = 1;
    #1;
    chk("rr1_m0_arready", 256'(m0_arready), 256'(1'b1));
    chk("rr1_m1_arready", 256'(m1_arready), 256'(1'b0));
    step();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = rdata_b; s_rid = 4'd2; s_rresp = 2'b00; s_rlast = 1; m0_rready = 1;
    #1;
    chk("rr1_m0_rvalid", 256'(m0_rvalid), 256'(1'b1));
    chk("rr1_m1_rvalid", 256'(m1_rvalid), 256'(1'b0));
    step();
    // back in IDLE; m0 asks again alongside the still-waiting m1
    s_rvalid = 0; m0_rready = 0;
    m0_arvalid = 1; m0_araddr = 32'h1000; m0_arid = 4'd3;
    #1;
    chk("rr_reidle_rd_gnt", 256'(rd_gnt), 256'(2'b00));
    step();
    chk("rr2_rd_gnt", 256'(rd_gnt), 256'(2'b10));
    chk("rr2_s_araddr", 256'(s_araddr), 256'(32'hB0));
    chk("rr2_s_arid", 256'(s_arid), 256'(4'd1));
    s_arready = 1;
    #1;
    chk("rr2_m1_arready", 256'(m1_arready), 256'(1'b1));
    chk("rr2_m0_arready", 256'(m0_arready), 256'(1'b0));
    step();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = rdata_b; s_rid = 4'd1; s_rlast = 1; m1_rready = 1;
    #1;
    chk("rr2_m1_rvalid", 256'(m1_rvalid), 256'(1'b1));
    chk("rr2_m0_rvalid", 256'(m0_rvalid), 256'(1'b0));
    step();

    // ---- m0 lone read 0x1000 (its request has been held since above) ----
    s_rvalid = 0; m1_rready = 0;
    #1;
    chk("m0rd_idle_s_arvalid", 256'(s_arvalid), 256'(1'b0));
    step();
    chk("m0rd_s_arvalid", 256'(s_arvalid), 256'(1'b1));
    chk("m0rd_s_araddr", 256'(s_araddr), 256'(32'h1000));
    chk("m0rd_m0_arready_wait", 256'(m0_arready), 256'(1'b0));
    s_arready = 1;
    step();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = rdata_a; s_rid = 4'd3; s_rresp = 2'b00; s_rlast = 1; m0_rready = 1;
    #1;
    chk("m0rd_m0_rvalid", 256'(m0_rvalid), 256'(1'b1));
    chk("m0rd_m0_rdata", m0_rdata, rdata_a);
    chk("m0rd_m0_rid", 256'(m0_rid), 256'(4'd3));
    chk("m0rd_m1_rvalid", 256'(m1_rvalid), 256'(1'b0));
    chk("m0rd_s_rready", 256'(s_rready), 256'(1'b1));
    step();
    s_rvalid = 0; m0_rready = 0;
    #1;
    chk("m0rd_done_rd_gnt", 256'(rd_gnt), 256'(2'b00));

    // ---- m1 write 0x2000 overlapping m0 read 0x0 ----
    m1_awvalid = 1; m1_awaddr = 32'h2000; m1_awid = 4'd5;
    m0_arvalid = 1; m0_araddr = 32'h0; m0_arid = 4'd6;
    step();
    chk("ovl_wr_gnt", 256'(wr_gnt), 256'(2'b10));
    chk("ovl_rd_gnt", 256'(rd_gnt), 256'(2'b01));
    chk("ovl_s_awaddr", 256'(s_awaddr), 256'(32'h2000));
    chk("ovl_s_awid", 256'(s_awid), 256'(4'd5));
    chk("ovl_s_araddr", 256'(s_araddr), 256'(32'h0));
    s_awready = 1; s_arready = 1;
    step();
    m1_awvalid = 0; m0_arvalid = 0; s_awready = 0; s_arready = 0;
    m1_wvalid = 1; m1_wdata = wdata_a; m1_wstrb = '1; m1_wlast = 1;
    s_rvalid = 1; s_rdata = rdata_a; s_rid = 4'd6; s_rresp = 2'b00; s_rlast = 1; m0_rready = 1;
    #1;
    chk("ovl_s_wvalid", 256'(s_wvalid), 256'(1'b1));
    chk("ovl_s_wdata", s_wdata, wdata_a);
    chk("ovl_s_wstrb", 256'(s_wstrb), 256'({32{1'b1}}));
    chk("ovl_m1_wready_wait", 256'(m1_wready), 256'(1'b0));
    chk("ovl_m0_rvalid", 256'(m0_rvalid), 256'(1'b1));
    chk("ovl_m0_rresp", 256'(m0_rresp), 256'(2'b00));
    s_wready = 1;
    #1;
    chk("ovl_m1_wready", 256'(m1_wready), 256'(1'b1));
    step();
    m1_wvalid = 0; s_wready = 0; s_rvalid = 0; m0_rready = 0;
    s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'd5; m1_bready = 1;
    #1;
    chk("ovl_rd_done", 256'(rd_gnt), 256'(2'b00));
    chk("ovl_m1_bvalid", 256'(m1_bvalid), 256'(1'b1));
    chk("ovl_m0_bvalid", 256'(m0_bvalid), 256'(1'b0));
    chk("ovl_m1_bid", 256'(m1_bid), 256'(4'd5));
    chk("ovl_m1_bresp", 256'(m1_bresp), 256'(2'b00));
    chk("ovl_s_bready", 256'(s_bready), 256'(1'b1));
    step();
    s_bvalid = 0; m1_bready = 0;
    #1;
    chk("ovl_wr_done", 256'(wr_gnt), 256'(2'b00));

    // ---- m1 read with SLVERR ----
    m1_arvalid = 1; m1_araddr = 32'h80; m1_arid = 4'd4;
    step();
    s_arready = 1;
    step();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rresp = 2'b10; s_rid = 4'd4; s_rlast = 1; m1_rready = 1;
    #1;
    chk("err_m1_rvalid", 256'(m1_rvalid), 256'(1'b1));
    chk("err_m1_rresp", 256'(m1_rresp), 256'(2'b10));
    step();
    s_rvalid = 0; s_rresp = 2'b00; m1_rready = 0;
    #1;
    chk("err_rd_state", 256'(dbg_rd_state), 256'(2'd0));

    // ---- m0 backpressure: rready low for 5 cycles ----
    m0_arvalid = 1; m0_araddr = 32'h3000; m0_arid = 4'd7;
    step();
    s_arready = 1;
    step();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = rdata_b; s_rid = 4'd7; s_rlast = 1; m0_rready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_s_rready_low", 256'(s_rready), 256'(1'b0));
      chk("bp_rd_gnt", 256'(rd_gnt), 256'(2'b01));
      step();
    end
    m0_rready = 1;
    #1;
    chk("bp_s_rready_rel", 256'(s_rready), 256'(1'b1));
    chk("bp_m0_rdata", m0_rdata, rdata_b);
    step();
    s_rvalid = 0; m0_rready = 0;
    #1;
    chk("bp_done_rd_gnt", 256'(rd_gnt), 256'(2'b00));

    // ---- reset in WR_DATA, after an m0 grant moved the pointer to m1 ----
    m0_awvalid = 1; m0_awaddr = 32'h4000; m0_awid = 4'd9;
    step();
    s_awready = 1;
    step();
    m0_awvalid = 0; s_awready = 0;
    m0_wvalid = 1; m0_wdata = wdata_a; m0_wstrb = '1; m0_wlast = 0; s_wready = 1;
    #1;
    chk("rstw_pre_s_wvalid", 256'(s_wvalid), 256'(1'b1));
    chk("rstw_pre_m0_wready", 256'(m0_wready), 256'(1'b1));
    rst = 1;
    #1;
    chk("rstw_s_wvalid", 256'(s_wvalid), 256'(1'b0));
    chk("rstw_m0_wready", 256'(m0_wready), 256'(1'b0));
    chk("rstw_wr_gnt", 256'(wr_gnt), 256'(2'b00));
    m0_wvalid = 0; s_wready = 0;
    step();
    m0_awvalid = 1; m0_awaddr = 32'h5000;
    m1_awvalid = 1; m1_awaddr = 32'h6000;
    rst = 0;
    step();
    chk("rstw_after_wr_gnt", 256'(wr_gnt), 256'(2'b01));
    chk("rstw_after_s_awaddr", 256'(s_awaddr), 256'(32'h5000));
    chk("rstw_after_s_awvalid", 256'(s_awvalid), 256'(1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
